inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage that sits directly upstream of the processor and supplies its 32-bit `inst` word. It owns the program counter and a loadable instruction memory, and prefetches into a 2-entry queue with a valid/ready handshake. It redirects on a branch-skip request from the processor and stops at a HALT opcode.

## Interface

- `PC_W`, 8: program counter width; instruction memory depth is 2^PC_W words.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_en` in 1: instruction memory write strobe, honoured only in IDLE.
- `load_addr` in PC_W: write address.
- `load_data` in 32: write data.
- `start` in 1: one-cycle pulse; begins execution at PC 0 from IDLE or HALT.
- `skip` in 1: branch-taken pulse from the processor; skip the instruction after the last delivered one.
- `inst_ready` in 1: consumer accepts `inst_out` this cycle.
- `inst_out` out 32: head-of-queue instruction.
- `inst_valid` out 1: `inst_out` is valid.
- `pc_out` out PC_W: address of `inst_out`.
- `running` out 1: high in RUN.
- `halted` out 1: high in HALT.

## Operation

- **States:** IDLE, RUN, HALT. Reset enters IDLE.
  - IDLE→RUN on `start`.
  - RUN→HALT when a HALT instruction (opcode bits [31:29] = 3'b111) is handshaken.
  - HALT→RUN on `start`.
  - `start` in RUN restarts: flush, fetch_pc←0.
- **Instruction memory:** synchronous read with 1-cycle latency. Writes occur only when `load_en` is high and the state is IDLE; `load_en` in RUN or HALT is ignored.
- **Fetch issue:** in RUN, a read of fetch_pc is issued when (queue_count + inflight − pop) < 2, where pop = `inst_valid` & `inst_ready`. Each issue increments fetch_pc modulo 2^PC_W, so the PC wraps to 0 after 2^PC_W−1. An issued read returns next cycle and is pushed with its PC.
- **Handshake:** a transfer occurs when `inst_valid` & `inst_ready`. `inst_out` and `pc_out` hold stable while valid and not ready. `inst_valid` is never high outside RUN.
- **last_pc:** register holding the PC of the most recent transfer. It is cleared to 0 on `start`.
- **Skip:**
  - On `skip`, flush the queue and discard any in-flight read. Set fetch_pc ← base + 2, where base is the PC transferring this cycle if a transfer coincides, else last_pc.
  - Fetch resumes the following cycle.
  - `skip` outside RUN is ignored.
  - `skip` and `start` in the same cycle: `start` wins.
- **HALT:** on transfer of a HALT instruction, flush the queue and in-flight read, stop issuing, and enter HALT. `skip` in that same cycle is ignored.
- **Reset mid-operation:** state→IDLE, queue empty, inflight=0, fetch_pc=0, last_pc=0. Memory contents are not reset.

## Timing

- **Reset values:** `inst_out`=0, `inst_valid`=0, `pc_out`=0, `running`=0, `halted`=0.
- **Start latency:** `start` sampled at edge E0 → first read issued at E1 → `inst_valid` high after E2, with `pc_out`=0.
- **Throughput:** with `inst_ready` held high, one instruction per cycle, consecutive PCs.
- **Skip latency:** `skip` at edge E → `inst_valid` low after E and E+1 → valid again after E+2 with `pc_out` = base+2.
- **Back-pressure:** the queue holds at most 2 entries. With `inst_ready` low the queue fills and issue stops; no instruction is lost or duplicated.
- **Load:** a write at edge E is visible to a read issued at E+1 or later.

## Test plan

- **Load and run:** load words 0..4, `start`, `inst_ready`=1 → `inst_valid` rises 2 cycles after `start`; PCs 0,1,2,3,4 on consecutive cycles with matching data.
- **Back-pressure:** `inst_ready`=0 for 5 cycles mid-stream → `inst_out` and `pc_out` stable. When released, delivery resumes with no gap in the PC sequence and no duplicates.
- **Skip:** `skip` pulsed in the same cycle as the PC 3 transfer → PC 4 is never delivered; next delivered `pc_out`=5, two cycles of `inst_valid`=0 between.
- **HALT:** word 2 = 32'hE000_0000 → PCs 0,1,2 delivered, then `halted`=1 and `inst_valid`=0 forever. A following `start` restarts at PC 0.
- **Wrap:** `PC_W`=3, no HALT in memory → PC sequence 6,7,0,1.
- **Reset and IDLE load:** assert `rst_n` low mid-stream → all outputs 0 immediately, without waiting for a clock edge. A `load_en` write in RUN does not change memory, verified on the next run.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-to-consumer instruction handshake.
//   inst_out   : head-of-queue instruction word
//   inst_valid : inst_out/pc_out are valid
//   pc_out     : address of inst_out
//   inst_ready : consumer accepts inst_out this cycle
interface inst_fetch_if #(
  parameter int unsigned PC_W = 8
) ();
  logic [31:0]     inst_out;
  logic            inst_valid;
  logic [PC_W-1:0] pc_out;
  logic            inst_ready;

  modport master (output inst_out, inst_valid, pc_out, input inst_ready);
  modport slave  (input inst_out, inst_valid, pc_out, output inst_ready);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and a loadable instruction memory,
// prefetches into a 2-entry queue, redirects on skip and stops on HALT.
//   clk, rst_n          : clock, async active-low reset
//   load_en/addr/data   : instruction memory write port (IDLE only)
//   start               : begin/restart execution at PC 0
//   skip                : skip the instruction after the last delivered one
//   ifc (master)        : inst_out / inst_valid / pc_out / inst_ready
//   running, halted     : state indicators
module inst_fetch #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_data,
  input  logic            start,
  input  logic            skip,
  inst_fetch_if.master    ifc,
  output logic            running,
  output logic            halted
);

  localparam int unsigned DEPTH = 1 << PC_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t state_q, state_d;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_data;
  logic [PC_W-1:0]       rd_pc_q;
  logic [1:0][31:0]      q_inst_q, q_inst_d;
  logic [1:0][PC_W-1:0]  q_pc_q, q_pc_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  valid_q;
  logic [PC_W-1:0]       fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]       last_pc_q, last_pc_d;

  logic                  pop_c, push_c, issue_c, flush_c;
  logic                  halt_xfer_c, skip_take_c, slot_c;
  logic [2:0]            occ_c;
  logic [PC_W-1:0]       base_c;

  // Next-state, queue and PC control
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    last_pc_d   = last_pc_q;
    q_inst_d    = q_inst_q;
    q_pc_d      = q_pc_q;
    flush_c     = 1'b0;
    skip_take_c = 1'b0;
    issue_c     = 1'b0;

    pop_c       = valid_q & ifc.inst_ready;
    halt_xfer_c = pop_c & (q_inst_q[0][31:29] == 3'b111);
    base_c      = pop_c ? q_pc_q[0] : last_pc_q;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        // start beats HALT and skip; HALT beats skip
        if (start) begin
          flush_c = 1'b1;
        end else if (halt_xfer_c) begin
          state_d = S_HALT;
          flush_c = 1'b1;
        end else if (skip) begin
          flush_c     = 1'b1;
          skip_take_c = 1'b1;
        end
      end
      S_HALT: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Slots held or about to land after this cycle's pop
    occ_c   = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
    issue_c = (state_q == S_RUN) && !flush_c && (occ_c < 3'd2);
    push_c  = inflight_q & ~flush_c;
    // count - pop is 0 or 1 whenever a push lands
    slot_c  = (count_q != 2'(pop_c));

    if (flush_c) count_d = 2'd0;
    else         count_d = count_q + 2'(push_c) - 2'(pop_c);

    if (pop_c) begin
      q_inst_d[0] = q_inst_q[1];
      q_pc_d[0]   = q_pc_q[1];
    end
    if (push_c) begin
      q_inst_d[slot_c] = rd_data;
      q_pc_d[slot_c]   = rd_pc_q;
    end

    if (start)            fetch_pc_d = '0;
    else if (skip_take_c) fetch_pc_d = base_c + PC_W'(2);
    else if (issue_c)     fetch_pc_d = fetch_pc_q + PC_W'(1);

    if (start)      last_pc_d = '0;
    else if (pop_c) last_pc_d = q_pc_q[0];
  end

  // State and queue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      fetch_pc_q <= '0;
      last_pc_q  <= '0;
      rd_pc_q    <= '0;
      q_inst_q   <= '0;
      q_pc_q     <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= issue_c;
      valid_q    <= (count_d != 2'd0);
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
      q_inst_q   <= q_inst_d;
      q_pc_q     <= q_pc_d;
      running    <= (state_d == S_RUN);
      halted     <= (state_d == S_HALT);
      if (issue_c) rd_pc_q <= fetch_pc_q;
    end
  end

  // Instruction memory: writable only in IDLE, 1-cycle synchronous read
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE)) mem[load_addr] <= load_data;
    if (issue_c) rd_data <= mem[fetch_pc_q];
  end

  assign ifc.inst_out   = q_inst_q[0];
  assign ifc.inst_valid = valid_q;
  assign ifc.pc_out     = q_pc_q[0];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a scoreboard model predicts the
// delivered (pc, word) stream from memory contents, start/skip/HALT rules
// and observed handshakes; a second small instance covers PC wrap.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load_en, start, skip;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        running, halted;

  logic        w_load_en, w_start, w_skip;
  logic [2:0]  w_load_addr;
  logic [31:0] w_load_data;
  logic        w_running, w_halted;

  inst_fetch_if #(.PC_W(8)) m_if ();
  inst_fetch_if #(.PC_W(3)) w_if ();

  inst_fetch #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .skip(skip), .ifc(m_if),
    .running(running), .halted(halted)
  );

  inst_fetch #(.PC_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .load_en(w_load_en), .load_addr(w_load_addr),
    .load_data(w_load_data), .start(w_start), .skip(w_skip), .ifc(w_if),
    .running(w_running), .halted(w_halted)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=unexpected-transfer exp=none", nm);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] pc; logic [31:0] data; } exp_t;
  typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

  exp_t        exp_q[$];
  exp_t        wq[$];
  logic [31:0] mem_m [256];
  mstate_t     m_state = M_IDLE;
  logic [7:0]  m_last = 8'd0;
  logic [7:0]  m_next = 8'd0;
  bit          m_stop = 1'b0;
  int          quiet = 0;

  // Keep the next few predicted deliveries queued; nothing follows a HALT
  task automatic fill();
    while (!m_stop && exp_q.size() < 4) begin
      exp_t e;
      e.pc   = m_next;
      e.data = mem_m[m_next];
      exp_q.push_back(e);
      if (e.data[31:29] == 3'b111) m_stop = 1'b1;
      m_next = m_next + 8'd1;
    end
  endtask

  task automatic restart(input logic [7:0] p);
    exp_q.delete();
    m_next = p;
    m_stop = 1'b0;
    fill();
  endtask

  // Monitor + model, sampled on the falling edge
  always @(negedge clk) begin
    exp_t head;
    bit   xfer;
    if (!rst_n) begin
      m_state = M_IDLE;
      exp_q.delete();
      quiet   = 0;
      m_last  = 8'd0;
      m_stop  = 1'b0;
    end else begin
      xfer = 1'b0;
      head = '0;
      chk("running", 64'(running), 64'(m_state == M_RUN));
      chk("halted", 64'(halted), 64'(m_state == M_HALT));
      if (m_state != M_RUN)  chk("valid_outside_run", 64'(m_if.inst_valid), 64'd0);
      else if (quiet >= 2)   chk("valid_gap", 64'(m_if.inst_valid), 64'd0);
      else                   chk("valid_stream", 64'(m_if.inst_valid), 64'd1);
      if (quiet > 0) quiet--;

      if (m_state == M_RUN && m_if.inst_valid) begin
        if (exp_q.size() == 0) begin
          note_fail("stream_extra");
        end else begin
          head = exp_q[0];
          chk("pc_out", 64'(m_if.pc_out), 64'(head.pc));
          chk("inst_out", 64'(m_if.inst_out), 64'(head.data));
          if (m_if.inst_ready) begin
            xfer = 1'b1;
            void'(exp_q.pop_front());
            m_last = head.pc;
            fill();
          end
        end
      end

      // Apply what the next rising edge will see
      if (load_en && m_state == M_IDLE) mem_m[load_addr] = load_data;
      if (start) begin
        m_state = M_RUN;
        m_last  = 8'd0;
        restart(8'd0);
        quiet   = 3;
      end else if (m_state == M_RUN) begin
        if (xfer && head.data[31:29] == 3'b111) begin
          m_state = M_HALT;
          exp_q.delete();
        end else if (skip) begin
          restart(m_last + 8'd2);
          quiet = 3;
        end
      end
    end
  end

  // Wrap instance monitor
  always @(negedge clk) begin
    exp_t h;
    if (rst_n && w_if.inst_valid && w_if.inst_ready) begin
      if (wq.size() == 0) begin
        note_fail("wrap_extra");
      end else begin
        h = wq.pop_front();
        chk("wrap_pc", 64'(w_if.pc_out), 64'(h.pc));
        chk("wrap_inst", 64'(w_if.inst_out), 64'(h.data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (w[31:29] == 3'b111) w[31] = 1'b0;
    if (allow_halt && $urandom_range(0, 31) == 0) w[31:29] = 3'b111;
    return w;
  endfunction

  // Assert reset mid-cycle and check outputs clear without a clock edge
  task automatic async_reset();
    start = 1'b0; skip = 1'b0; load_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inst_out", 64'(m_if.inst_out), 64'd0);
    chk("rst_inst_valid", 64'(m_if.inst_valid), 64'd0);
    chk("rst_pc_out", 64'(m_if.pc_out), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b1;
    load_en = 1'b0; start = 1'b0; skip = 1'b0; load_addr = '0; load_data = '0;
    m_if.inst_ready = 1'b0;
    w_load_en = 1'b0; w_start = 1'b0; w_skip = 1'b0; w_load_addr = '0; w_load_data = '0;
    w_if.inst_ready = 1'b0;

    async_reset();

    // Fill memory; words 0..4 are recognisable
    for (int i = 0; i < 256; i++)
      load_word(8'(i), (i < 5) ? (32'h0000_1000 + 32'(i)) : rand_word(1'b0));

    // Load and run, then back-pressure mid-stream
    m_if.inst_ready = 1'b1;
    pulse_start();
    repeat (8) tick();
    m_if.inst_ready = 1'b0;
    repeat (5) tick();
    m_if.inst_ready = 1'b1;
    repeat (6) tick();

    // Restart in RUN, skip coincident with PC 3 transfer
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (m_if.inst_valid && m_if.pc_out == 8'd3) found = 1'b1;
    end
    skip = found;
    tick();
    skip = 1'b0;
    chk("skip_pc3_seen", 64'(found), 64'd1);
    repeat (2) tick();
    // Write while running must be ignored
    load_word(8'd0, 32'hDEAD_0000);
    repeat (6) tick();
    async_reset();

    // HALT at word 2, then restart from HALT
    load_word(8'd2, 32'hE000_0000);
    pulse_start();
    repeat (12) tick();
    pulse_start();
    repeat (10) tick();
    async_reset();

    // Randomised traffic over a fresh memory image with sparse HALTs
    for (int i = 0; i < 256; i++) load_word(8'(i), rand_word(1'b1));
    for (int c = 0; c < 3000; c++) begin
      m_if.inst_ready = ($urandom_range(0, 9) < 7);
      skip      = ($urandom_range(0, 19) == 0);
      start     = running ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0);
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = 8'($urandom_range(0, 255));
      load_data = rand_word(1'b1);
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    start = 1'b0; skip = 1'b0; load_en = 1'b0; m_if.inst_ready = 1'b0;
    repeat (3) tick();

    // Wrap on the PC_W=3 instance: 0..7 then 0,1
    for (int i = 0; i < 8; i++) begin
      w_load_en = 1'b1; w_load_addr = 3'(i); w_load_data = 32'h0000_0A00 + 32'(i);
      tick();
    end
    w_load_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.pc   = 8'(k % 8);
      e.data = 32'h0000_0A00 + 32'(k % 8);
      wq.push_back(e);
    end
    w_if.inst_ready = 1'b1;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 40 && wq.size() != 0; k++) tick();
    w_if.inst_ready = 1'b0;
    chk("wrap_drain", 64'(wq.size()), 64'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
